hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage MIPS pipeline. It works alongside the EX-stage forwarding unit. It covers the cases forwarding cannot resolve:
- load-use stalls on the ID-stage instruction;
- wrong-path flushes on a taken EX-stage branch;
- stalls for HI/LO consumers while the multi-cycle multiply/divide unit is busy.

It drives the PC and IF/ID write enables, the IF/ID and ID/EX flushes, the MDU start strobe, and a saturating stall-cycle performance counter.

## Interface
- MULT_LAT, 4: multiply latency in cycles (≥1)
- DIV_LAT, 16: divide latency in cycles (≥1)
- CNT_W, 5: MDU countdown width; must hold max(MULT_LAT, DIV_LAT)-1

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- rs_ID  input  5  rs field of the ID-stage instruction
- rt_ID  input  5  rt field of the ID-stage instruction
- ID_useRs  input  1  ID instruction reads rs
- ID_useRt  input  1  ID instruction reads rt
- WriteDst_EX  input  5  destination register of the EX-stage instruction
- EX_ctrl_MemRd  input  1  EX-stage instruction is a load
- EX_branchTaken  input  1  branch/jump resolved taken in EX
- ID_isMdu  input  1  ID instruction is mult/multu/div/divu
- ID_isDiv  input  1  qualifies ID_isMdu: 1 = divide, 0 = multiply
- ID_readsHiLo  input  1  ID instruction is mfhi/mflo/mthi/mtlo
- PC_wr  output  1  PC write enable
- IFID_wr  output  1  IF/ID register write enable
- IFID_flush  output  1  clear IF/ID to nop
- IDEX_flush  output  1  insert bubble into ID/EX
- mdu_start  output  1  one-cycle MDU launch strobe
- mdu_busy  output  1  MDU operation in flight
- stall_cnt  output  16  count of stall cycles, saturating

## Operation
- Load-use hazard: lu = EX_ctrl_MemRd && WriteDst_EX != 0 && ((ID_useRs && rs_ID == WriteDst_EX) || (ID_useRt && rt_ID == WriteDst_EX)).
- MDU hazard: mh = mdu_busy && (ID_isMdu || ID_readsHiLo).
- stall = (lu || mh) && !EX_branchTaken.
- State machine, two states:
  - IDLE: mdu_busy=0.
  - BUSY: mdu_busy=1, cnt = remaining cycles - 1.
- Accept: mdu_start = ID_isMdu && !stall && !EX_branchTaken && !rst. It can only assert in IDLE, because any MDU op in BUSY gives mh=1.
- IDLE→BUSY on accept; cnt loads DIV_LAT-1 or MULT_LAT-1 per ID_isDiv.
- BUSY:
  - cnt != 0: cnt decrements.
  - cnt == 0: next state IDLE.
  - mdu_busy is therefore high for exactly LAT cycles, starting the cycle after mdu_start.
- Output priority, highest first:
  1. rst: PC_wr=0, IFID_wr=0, IFID_flush=1, IDEX_flush=1, mdu_start=0.
  2. EX_branchTaken: PC_wr=1, IFID_wr=1, IFID_flush=1, IDEX_flush=1. The ID instruction is wrong-path and is discarded with no stall.
  3. stall: PC_wr=0, IFID_wr=0, IFID_flush=0, IDEX_flush=1.
  4. Otherwise: PC_wr=1, IFID_wr=1, both flushes 0.
- stall_cnt increments by 1 on each clock edge where stall=1 and rst=0. It holds at 16'hFFFF once reached.

## Timing
- Hazard outputs are combinational from the current inputs plus registered state; no added latency.
- The load-use stall lasts exactly one cycle: after the bubble, the load has moved to MEM and is forwarded from there.
- Reset values: state IDLE, cnt 0, mdu_busy 0, stall_cnt 0. Flush and write-enable outputs follow priority rule 1 while rst is high.
- Reset mid-BUSY returns to IDLE on the next edge; the in-flight MDU result is abandoned.
- Taken branch in the same cycle as lu or mh: the branch wins, stall=0, stall_cnt unchanged.
- Taken branch in the same cycle as an ID-stage MDU op: no mdu_start.
- mh at the last BUSY cycle (cnt==0): stall asserts. The ID instruction proceeds on the following cycle, when mdu_busy=0.

## Test plan
- Load-use: EX lw writing $8 (EX_ctrl_MemRd=1, WriteDst_EX=8), ID add with rs_ID=8, ID_useRs=1. Required: one cycle with PC_wr=0, IFID_wr=0, IDEX_flush=1; stall_cnt 0→1; next cycle normal.
- Register $0 and unused fields: WriteDst_EX=0 with rs_ID=0 gives no stall. rt match with ID_useRt=0 gives no stall.
- Multiply then mfhi: mult accepted (mdu_start=1), so mdu_busy=1 for 4 cycles. mfhi in ID the cycle after accept stalls 4 cycles; stall_cnt=4; mfhi proceeds in cycle 5.
- Back-to-back div: a second div arriving while BUSY stalls 16 cycles. mdu_start pulses once per div, 17 cycles apart.
- Branch priority: EX_branchTaken=1 together with a load-use match and an ID mult. Required: PC_wr=1, IFID_flush=1, IDEX_flush=1, mdu_start=0, stall_cnt unchanged.
- Reset mid-divide: rst asserted at BUSY cnt=9. Required: next cycle mdu_busy=0, stall_cnt=0, and a pending mfhi no longer stalls.

Source files
------------

// File: rtl/hazard_if.sv
// Hazard controller bus: ID/EX hazard inputs from the pipeline, stall/flush/MDU controls back.
interface hazard_if;
  logic [4:0]  rs_ID;
  logic [4:0]  rt_ID;
  logic        ID_useRs;
  logic        ID_useRt;
  logic [4:0]  WriteDst_EX;
  logic        EX_ctrl_MemRd;
  logic        EX_branchTaken;
  logic        ID_isMdu;
  logic        ID_isDiv;
  logic        ID_readsHiLo;
  logic        PC_wr;
  logic        IFID_wr;
  logic        IFID_flush;
  logic        IDEX_flush;
  logic        mdu_start;
  logic        mdu_busy;
  logic [15:0] stall_cnt;

  modport master (
    output rs_ID, rt_ID, ID_useRs, ID_useRt, WriteDst_EX, EX_ctrl_MemRd,
           EX_branchTaken, ID_isMdu, ID_isDiv, ID_readsHiLo,
    input  PC_wr, IFID_wr, IFID_flush, IDEX_flush, mdu_start, mdu_busy, stall_cnt
  );

  modport slave (
    input  rs_ID, rt_ID, ID_useRs, ID_useRt, WriteDst_EX, EX_ctrl_MemRd,
           EX_branchTaken, ID_isMdu, ID_isDiv, ID_readsHiLo,
    output PC_wr, IFID_wr, IFID_flush, IDEX_flush, mdu_start, mdu_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use / MDU-busy stall and taken-branch flush controller for the 5-stage pipeline.
// State | meaning: IDLE | no MDU op in flight ; BUSY | MDU op running, cnt = remaining cycles - 1
module hazard_ctrl #(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 16,
  parameter int CNT_W    = 5
) (
  input logic     clk,
  input logic     rst,
  hazard_if.slave hz
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic [15:0]      stall_cnt;
  logic             lu;
  logic             mh;
  logic             stall;
  logic             accept;

  always_comb begin
    lu = hz.EX_ctrl_MemRd && (hz.WriteDst_EX != 5'd0) &&
         ((hz.ID_useRs && (hz.rs_ID == hz.WriteDst_EX)) ||
          (hz.ID_useRt && (hz.rt_ID == hz.WriteDst_EX)));
    mh     = busy && (hz.ID_isMdu || hz.ID_readsHiLo);
    stall  = (lu || mh) && !hz.EX_branchTaken;
    accept = hz.ID_isMdu && !stall && !hz.EX_branchTaken && !rst;
  end

  always_comb begin
    hz.PC_wr      = 1'b1;
    hz.IFID_wr    = 1'b1;
    hz.IFID_flush = 1'b0;
    hz.IDEX_flush = 1'b0;
    hz.mdu_start  = accept;
    if (rst) begin
      hz.PC_wr      = 1'b0;
      hz.IFID_wr    = 1'b0;
      hz.IFID_flush = 1'b1;
      hz.IDEX_flush = 1'b1;
    end else if (hz.EX_branchTaken) begin
      hz.IFID_flush = 1'b1;
      hz.IDEX_flush = 1'b1;
    end else if (stall) begin
      hz.PC_wr      = 1'b0;
      hz.IFID_wr    = 1'b0;
      hz.IDEX_flush = 1'b1;
    end
  end

  assign hz.mdu_busy  = busy;
  assign hz.stall_cnt = stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      stall_cnt <= 16'd0;
    end else begin
      if (stall && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
      case (state)
        IDLE: begin
          if (accept) begin
            state <= BUSY;
            busy  <= 1'b1;
            cnt   <= hz.ID_isDiv ? CNT_W'(DIV_LAT - 1) : CNT_W'(MULT_LAT - 1);
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl with hand-computed expectations.
module tb_hazard_ctrl;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  hazard_if hz ();

  hazard_ctrl #(.MULT_LAT(4), .DIV_LAT(16), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clr();
    hz.rs_ID = 5'd0; hz.rt_ID = 5'd0; hz.ID_useRs = 1'b0; hz.ID_useRt = 1'b0;
    hz.WriteDst_EX = 5'd0; hz.EX_ctrl_MemRd = 1'b0; hz.EX_branchTaken = 1'b0;
    hz.ID_isMdu = 1'b0; hz.ID_isDiv = 1'b0; hz.ID_readsHiLo = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    clr();
    rst = 1'b1;
    hz.ID_isMdu = 1'b1;
    step(); step();
    chk("rst_pc_wr", hz.PC_wr, 0);
    chk("rst_ifid_wr", hz.IFID_wr, 0);
    chk("rst_ifid_flush", hz.IFID_flush, 1);
    chk("rst_idex_flush", hz.IDEX_flush, 1);
    chk("rst_mdu_start", hz.mdu_start, 0);
    chk("rst_busy", hz.mdu_busy, 0);
    chk("rst_stall_cnt", hz.stall_cnt, 0);
    clr();
    rst = 1'b0;
    step();

    // load-use on rs
    hz.EX_ctrl_MemRd = 1'b1; hz.WriteDst_EX = 5'd8; hz.rs_ID = 5'd8; hz.ID_useRs = 1'b1;
    #1;
    chk("lu_pc_wr", hz.PC_wr, 0);
    chk("lu_ifid_wr", hz.IFID_wr, 0);
    chk("lu_idex_flush", hz.IDEX_flush, 1);
    chk("lu_ifid_flush", hz.IFID_flush, 0);
    step();
    clr();
    #1;
    chk("lu_cnt", hz.stall_cnt, 1);
    chk("lu_after_pc_wr", hz.PC_wr, 1);
    chk("lu_after_idex_flush", hz.IDEX_flush, 0);

    // load-use on rt
    hz.EX_ctrl_MemRd = 1'b1; hz.WriteDst_EX = 5'd9; hz.rt_ID = 5'd9; hz.ID_useRt = 1'b1;
    #1;
    chk("lu_rt_pc_wr", hz.PC_wr, 0);
    step();
    hz.ID_useRt = 1'b0;
    #1;
    chk("rt_unused_pc_wr", hz.PC_wr, 1);
    chk("rt_cnt", hz.stall_cnt, 2);
    clr();
    hz.EX_ctrl_MemRd = 1'b1; hz.WriteDst_EX = 5'd0; hz.rs_ID = 5'd0; hz.ID_useRs = 1'b1;
    #1;
    chk("r0_pc_wr", hz.PC_wr, 1);
    chk("r0_idex_flush", hz.IDEX_flush, 0);
    step();
    clr();
    #1;
    chk("r0_cnt", hz.stall_cnt, 2);

    // mult then mfhi
    hz.ID_isMdu = 1'b1; hz.ID_isDiv = 1'b0;
    #1;
    chk("mult_start", hz.mdu_start, 1);
    chk("mult_pc_wr", hz.PC_wr, 1);
    step();
    clr();
    hz.ID_readsHiLo = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("mfhi_busy_%0d", i), hz.mdu_busy, 1);
      chk($sformatf("mfhi_stall_%0d", i), hz.PC_wr, 0);
      step();
    end
    chk("mfhi_busy_end", hz.mdu_busy, 0);
    chk("mfhi_proceed", hz.PC_wr, 1);
    chk("mfhi_cnt", hz.stall_cnt, 6);
    clr();
    step();

    // back-to-back div
    hz.ID_isMdu = 1'b1; hz.ID_isDiv = 1'b1;
    #1;
    chk("div1_start", hz.mdu_start, 1);
    step();
    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("div2_nostart_%0d", i), hz.mdu_start, 0);
      chk($sformatf("div2_stall_%0d", i), hz.PC_wr, 0);
      chk($sformatf("div2_busy_%0d", i), hz.mdu_busy, 1);
      step();
    end
    chk("div2_start", hz.mdu_start, 1);
    chk("div2_cnt", hz.stall_cnt, 22);
    step();
    clr();
    for (int i = 0; i < 16; i++) step();
    chk("div2_done", hz.mdu_busy, 0);

    // branch priority
    hz.EX_branchTaken = 1'b1; hz.EX_ctrl_MemRd = 1'b1; hz.WriteDst_EX = 5'd8;
    hz.rs_ID = 5'd8; hz.ID_useRs = 1'b1; hz.ID_isMdu = 1'b1;
    #1;
    chk("br_pc_wr", hz.PC_wr, 1);
    chk("br_ifid_wr", hz.IFID_wr, 1);
    chk("br_ifid_flush", hz.IFID_flush, 1);
    chk("br_idex_flush", hz.IDEX_flush, 1);
    chk("br_mdu_start", hz.mdu_start, 0);
    step();
    clr();
    #1;
    chk("br_busy", hz.mdu_busy, 0);
    chk("br_cnt", hz.stall_cnt, 22);

    // reset mid-divide at cnt=9
    hz.ID_isMdu = 1'b1; hz.ID_isDiv = 1'b1;
    #1;
    chk("rdiv_start", hz.mdu_start, 1);
    step();
    clr();
    for (int i = 0; i < 6; i++) step();
    chk("rdiv_busy", hz.mdu_busy, 1);
    hz.ID_readsHiLo = 1'b1;
    rst = 1'b1;
    #1;
    chk("rdiv_rst_flush", hz.IFID_flush, 1);
    step();
    rst = 1'b0;
    #1;
    chk("rdiv_busy_after", hz.mdu_busy, 0);
    chk("rdiv_cnt_after", hz.stall_cnt, 0);
    chk("rdiv_mfhi_go", hz.PC_wr, 1);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
